// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: opcodes, FSM states, byte-swap helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package stack_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_XTHL = 3'd2;
  localparam logic [2:0] OP_SPHL = 3'd3;
  localparam logic [2:0] OP_RDSP = 3'd4;
  localparam logic [2:0] OP_NOP  = 3'd5;  // any encoding above OP_RDSP behaves as NOP

  // Memory port 1 read latency; the RD_A/RD_W/RD_D sequence is built around it.
  localparam int MEM_RD_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_A,
    ST_RD_W,
    ST_RD_D,
    ST_RSP
  } state_t;

  // Memory returns {mem[a], mem[a+1]}; the stack keeps words little-endian.
  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Decoder-to-sequencer request/response channel.
// Latency: none (wiring only).
// Backpressure: request side uses req_ready; response is a pulse with no backpressure.
interface stack_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;

  modport master (output req_valid, req_op, req_data, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_op, req_data, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/stack_sp_reg.sv
// Stack pointer register with -2 / +2 / load datapath and optional bounds flag.
// Latency: updates visible the cycle after dec2/inc2/load is asserted.
// Backpressure: none; STACK_SEQ_BOUNDS_EN builds the sticky stk_err compare.
module stack_sp_reg #(
  parameter logic [15:0] STACK_LIMIT = 16'hC000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec2,
  input  logic        inc2,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] sp,
  output logic        stk_err
);

  logic [15:0] sp_dec;
  logic [15:0] sp_inc;

  assign sp_dec = sp - 16'd2;
  assign sp_inc = sp + 16'd2;

  // SP register; the FSM never asserts more than one update in a cycle.
  always_ff @(posedge clk) begin
    if (reset)     sp <= 16'h0000;
    else if (load) sp <= load_val;
    else if (dec2) sp <= sp_dec;
    else if (inc2) sp <= sp_inc;
  end

`ifdef STACK_SEQ_BOUNDS_EN
  logic pop_wraps;

  // SP of 0xFFFE or 0xFFFF carries out of 16 bits when incremented by 2.
  assign pop_wraps = &sp[15:1];

  // Sticky error: push dipping below the limit, or pop wrapping into the low region.
  always_ff @(posedge clk) begin
    if (reset)
      stk_err <= 1'b0;
    else if ((dec2 && (sp_dec < STACK_LIMIT)) ||
             (inc2 && pop_wraps && (sp_inc < STACK_LIMIT)))
      stk_err <= 1'b1;
  end
`else
  logic unused_limit;

  assign unused_limit = ^STACK_LIMIT;
  assign stk_err      = 1'b0;
`endif

endmodule

// File: rtl/stack_seq.sv
// Stack sequencer: turns PUSH/POP/XTHL/SPHL/RDSP requests into stack memory traffic.
// Latency: response 1 cycle after accept (PUSH/SPHL/RDSP/NOP), 3 cycles for POP/XTHL.
// Backpressure: req_ready only in IDLE; response pulse cannot stall. STACK_SEQ_BOUNDS_EN enables stk_err.
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [15:0] STACK_LIMIT = 16'hC000
) (
  input  logic         clk,
  input  logic         reset,
  stack_seq_if.slave   bus,
  output logic [15:0]  sp,
  output logic [15:0]  mem_raddr,
  input  logic [15:0]  mem_rdata,
  output logic         mem_wen0,
  output logic [15:0]  mem_waddr0,
  output logic [7:0]   mem_wdata0,
  output logic         mem_wen1,
  output logic [15:0]  mem_waddr1,
  output logic [7:0]   mem_wdata1,
  output logic         stk_err
);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic [15:0] data_q;
  logic [15:0] rd_word;
  logic        accept;
  logic        sp_dec2;
  logic        sp_inc2;
  logic        sp_load;

  assign accept  = bus.req_valid && (state == ST_IDLE);
  assign rd_word = swap_bytes(mem_rdata);

  stack_sp_reg #(.STACK_LIMIT(STACK_LIMIT)) u_sp (
    .clk      (clk),
    .reset    (reset),
    .dec2     (sp_dec2),
    .inc2     (sp_inc2),
    .load     (sp_load),
    .load_val (data_q),
    .sp       (sp),
    .stk_err  (stk_err)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Capture the request and launch the read address one cycle ahead of RD_A.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_NOP;
      data_q    <= 16'h0000;
      mem_raddr <= 16'h0000;
    end else if (accept) begin
      op_q   <= bus.req_op;
      data_q <= bus.req_data;
      if (bus.req_op == OP_POP || bus.req_op == OP_XTHL)
        mem_raddr <= sp;
    end
  end

  // Next state plus all per-state outputs; everything idles at zero.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 16'h0000;
    mem_wen0      = 1'b0;
    mem_waddr0    = 16'h0000;
    mem_wdata0    = 8'h00;
    mem_wen1      = 1'b0;
    mem_waddr1    = 16'h0000;
    mem_wdata1    = 8'h00;
    sp_dec2       = 1'b0;
    sp_inc2       = 1'b0;
    sp_load       = 1'b0;

    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_PUSH:         state_nxt = ST_WR;
            OP_POP, OP_XTHL: state_nxt = ST_RD_A;
            default:         state_nxt = ST_RSP;
          endcase
        end
      end
      ST_WR: begin
        mem_wen0      = 1'b1;
        mem_waddr0    = sp - 16'd1;
        mem_wdata0    = data_q[15:8];
        mem_wen1      = 1'b1;
        mem_waddr1    = sp - 16'd2;
        mem_wdata1    = data_q[7:0];
        sp_dec2       = 1'b1;
        bus.rsp_valid = 1'b1;
        state_nxt     = ST_IDLE;
      end
      ST_RD_A: state_nxt = ST_RD_W;
      ST_RD_W: state_nxt = ST_RD_D;
      ST_RD_D: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rd_word;
        if (op_q == OP_POP) begin
          sp_inc2 = 1'b1;
        end else begin
          // XTHL: old top already read; overwrite it with the new word in place.
          mem_wen0   = 1'b1;
          mem_waddr0 = sp + 16'd1;
          mem_wdata0 = data_q[15:8];
          mem_wen1   = 1'b1;
          mem_waddr1 = sp;
          mem_wdata1 = data_q[7:0];
        end
        state_nxt = ST_IDLE;
      end
      ST_RSP: begin
        bus.rsp_valid = 1'b1;
        case (op_q)
          OP_SPHL: sp_load      = 1'b1;
          OP_RDSP: bus.rsp_data = sp;
          default: ;
        endcase
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_seq.sv
// Randomized scoreboard bench for stack_seq with a byte-array stack reference model.
// Latency: responses checked against accept cycle + 1 or + 3.
// Backpressure: requests held until req_ready; STACK_SEQ_BOUNDS_EN selects stk_err expectation.
module tb_stack_seq;
  import stack_pkg::*;

  localparam logic [15:0] LIMIT = 16'hC000;

  typedef struct {
    logic [15:0] data;
    logic [15:0] sp;
    logic        err;
    int          t_rsp;
  } rsp_exp_t;

  typedef struct {
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] a1;
    logic [7:0]  d1;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sp, mem_raddr, mem_rdata;
  logic        mem_wen0, mem_wen1;
  logic [15:0] mem_waddr0, mem_waddr1;
  logic [7:0]  mem_wdata0, mem_wdata1;
  logic        stk_err;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_sp;
  logic        ref_err;
  logic [15:0] rd_a1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stack_seq_if bus();

  stack_seq #(.STACK_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sp         (sp),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wen0   (mem_wen0),
    .mem_waddr0 (mem_waddr0),
    .mem_wdata0 (mem_wdata0),
    .mem_wen1   (mem_wen1),
    .mem_waddr1 (mem_waddr1),
    .mem_wdata1 (mem_wdata1),
    .stk_err    (stk_err)
  );

  // Unified memory: two byte write ports, one word read port with 2-cycle latency.
  always @(posedge clk) begin
    if (mem_wen0) mem[mem_waddr0] <= mem_wdata0;
    if (mem_wen1) mem[mem_waddr1] <= mem_wdata1;
    rd_a1     <= mem_raddr;
    mem_rdata <= {mem[rd_a1], mem[rd_a1 + 16'd1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: stack as a byte array, SP as a plain 16-bit number.
  task automatic model(input logic [2:0] op, input logic [15:0] d,
                       output rsp_exp_t e, output bit has_wr, output wr_exp_t w);
    logic [15:0] hi_a, lo_a;
    logic [16:0] wide;
    has_wr = 0;
    e.data = 16'h0000;
    e.t_rsp = 1;
    w = '{a0: 16'h0, d0: 8'h0, a1: 16'h0, d1: 8'h0};
    case (op)
      3'd0: begin
        hi_a = ref_sp - 16'd1;
        lo_a = ref_sp - 16'd2;
        w = '{a0: hi_a, d0: d[15:8], a1: lo_a, d1: d[7:0]};
        has_wr = 1;
        ref_mem[hi_a] = d[15:8];
        ref_mem[lo_a] = d[7:0];
        ref_sp = lo_a;
        if (ref_sp < LIMIT) ref_err = 1'b1;
      end
      3'd1, 3'd2: begin
        lo_a = ref_sp;
        hi_a = ref_sp + 16'd1;
        e.data = {ref_mem[hi_a], ref_mem[lo_a]};
        e.t_rsp = 3;
        if (op == 3'd1) begin
          wide = {1'b0, ref_sp} + 17'd2;
          if (wide[16] && (wide[15:0] < LIMIT)) ref_err = 1'b1;
          ref_sp = wide[15:0];
        end else begin
          w = '{a0: hi_a, d0: d[15:8], a1: lo_a, d1: d[7:0]};
          has_wr = 1;
          ref_mem[hi_a] = d[15:8];
          ref_mem[lo_a] = d[7:0];
        end
      end
      3'd3: ref_sp = d;
      3'd4: e.data = ref_sp;
      default: ;
    endcase
    e.sp = ref_sp;
`ifdef STACK_SEQ_BOUNDS_EN
    e.err = ref_err;
`else
    e.err = 1'b0;
`endif
  endtask

  // Hold the request until accepted; expectations are queued at the accepting cycle.
  task automatic send(input logic [2:0] op, input logic [15:0] d, input bit expect_rsp);
    int n = 0;
    rsp_exp_t e;
    wr_exp_t  w;
    bit has_wr;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else if (expect_rsp) begin
      model(op, d, e, has_wr, w);
      e.t_rsp = cyc + e.t_rsp;
      rsp_q.push_back(e);
      if (has_wr) wr_q.push_back(w);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_data  = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) chk("drain_timeout", rsp_q.size(), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT responds or writes.
  initial begin
    bit       sp_pend = 0;
    rsp_exp_t pe;
    rsp_exp_t e;
    wr_exp_t  w;
    forever begin
      @(negedge clk);
      if (sp_pend) begin
        chk("sp_after", sp, pe.sp);
        chk("stk_err", stk_err, pe.err);
        sp_pend = 0;
      end
      if (!reset) begin
        if (bus.rsp_valid) begin
          if (rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
          else begin
            e = rsp_q.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_latency", cyc, e.t_rsp);
            pe = e;
            sp_pend = 1;
          end
        end
        if (mem_wen0 || mem_wen1) begin
          chk("wen_pair", {mem_wen0, mem_wen1}, 2'b11);
          chk("wr_with_rsp", bus.rsp_valid, 1'b1);
          if (wr_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
          else begin
            w = wr_q.pop_front();
            chk("wr_port0", {mem_waddr0, mem_wdata0}, {w.a0, w.d0});
            chk("wr_port1", {mem_waddr1, mem_wdata1}, {w.a1, w.d1});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      mem[i]     = b;
      ref_mem[i] = b;
    end
    ref_sp = 16'h0000;
    ref_err = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_data  = 16'h0000;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0000);
    chk("rst_sp", sp, 16'h0000);
    chk("rst_raddr", mem_raddr, 16'h0000);
    chk("rst_wen", {mem_wen0, mem_wen1}, 2'b00);
    chk("rst_waddr", {mem_waddr0, mem_waddr1}, 32'h0);
    chk("rst_stk_err", stk_err, 1'b0);
    @(posedge clk);
    #1;

    // Directed walk through the documented scenarios.
    send(OP_PUSH, 16'h1234, 1);
    send(OP_POP,  16'h0000, 1);
    send(OP_SPHL, 16'h2000, 1);
    send(OP_PUSH, 16'hBEEF, 1);
    send(OP_XTHL, 16'h5566, 1);
    drain();
    chk("xthl_mem_lo", mem[16'h1FFE], 8'h66);
    chk("xthl_mem_hi", mem[16'h1FFF], 8'h55);
    chk("xthl_sp", sp, 16'h1FFE);

    send(OP_SPHL, 16'h0001, 1);
    send(OP_RDSP, 16'h0000, 1);
    send(OP_PUSH, 16'hA55A, 1);
    drain();
    chk("wrap_mem_hi", mem[16'h0000], 8'hA5);
    chk("wrap_mem_lo", mem[16'hFFFF], 8'h5A);
    chk("wrap_sp", sp, 16'hFFFF);

    // Reset arriving the cycle after a POP is accepted.
    send(OP_SPHL, 16'h3456, 1);
    drain();
    send(OP_POP, 16'h0000, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ref_sp = 16'h0000;
    ref_err = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort_wen", {mem_wen0, mem_wen1}, 2'b00);
    chk("abort_sp", sp, 16'h0000);
    chk("abort_ready", bus.req_ready, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;

    // Bounds scenario; stk_err expectation follows the build configuration.
    send(OP_SPHL, 16'hC001, 1);
    send(OP_PUSH, 16'h7788, 1);
    send(OP_NOP,  16'h0000, 1);
    send(OP_POP,  16'h0000, 1);
    send(OP_RDSP, 16'h0000, 1);
    drain();

    // Randomized traffic; idle gaps and all eight opcodes.
    for (int k = 0; k < 400; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(3'($urandom_range(0, 7)), 16'($urandom), 1);
    end
    drain();
    chk("final_queue_empty", rsp_q.size() + wr_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
